// File: rtl/ber_pkg.sv
// Shared types and constants for the BER checker.
// State encoding, width helper and link defaults.
package ber_pkg;

    localparam int PRBS9_PERIOD = 511;
    localparam int OVERSAMPLE   = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } ber_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference delay line for the BER checker.
// Shift register of past reference bits plus the tap mux.
module ber_delay_line
    import ber_pkg::*;
#(
    parameter int MAX_DELAY = 512,
    parameter int DLY_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             din,
    input  logic [DLY_W-1:0] sel,
    output logic             tap
);

    logic [MAX_DELAY-1:0] ref_sr;
    logic [DLY_W-1:0]     idx;

    // Shift the newest reference bit into position 0 on each strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_sr <= '0;
        end else if (valid) begin
            ref_sr <= {ref_sr[MAX_DELAY-2:0], din};
        end
    end

    // Delay 0 compares against the live input; delay d uses the
    // bit that entered d strobes ago (before this strobe's shift).
    always_comb begin
        idx = sel - 1'b1;
        tap = (sel == '0) ? din : ref_sr[idx];
    end

endmodule

// File: rtl/ber_checker.sv
// PRBS bit-error-rate checker with automatic delay search.
// Fills the delay line, scans delays, locks and counts errors.
module ber_checker
    import ber_pkg::*;
#(
    parameter  int MAX_DELAY = 512,
    parameter  int WINDOW    = 128,
    parameter  int ERR_THR   = 8,
    parameter  int CNT_W     = 32,
    localparam int DLY_W     = clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             ref_in,
    input  logic             rx_in,
    output logic             locked,
    output logic [DLY_W-1:0] delay_out,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int WIN_W = clog2(WINDOW + 1);

    ber_state_t       state;
    logic [DLY_W-1:0] fill_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_err;

    logic             tap;
    logic             mismatch;
    logic [WIN_W-1:0] win_cnt_nx;
    logic [WIN_W-1:0] win_err_nx;
    logic             win_end;
    logic             thr_hit;
    logic             fill_last;
    logic [DLY_W-1:0] delay_inc;
    logic [CNT_W-1:0] bit_cnt_nx;
    logic [CNT_W-1:0] err_cnt_nx;

    ber_delay_line #(
        .MAX_DELAY (MAX_DELAY),
        .DLY_W     (DLY_W)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .din   (ref_in),
        .sel   (delay_out),
        .tap   (tap)
    );

    // Per-strobe next values for window, delay and counters.
    always_comb begin
        mismatch   = rx_in ^ tap;
        win_cnt_nx = win_cnt + 1'b1;
        win_err_nx = win_err + WIN_W'(mismatch);
        win_end    = (win_cnt_nx == WIN_W'(WINDOW));
        thr_hit    = (win_err_nx > WIN_W'(ERR_THR));
        fill_last  = (fill_cnt == DLY_W'(MAX_DELAY - 1));
        delay_inc  = (delay_out == DLY_W'(MAX_DELAY - 1))
                   ? '0 : delay_out + 1'b1;
        bit_cnt_nx = (&bit_count)
                   ? bit_count : bit_count + 1'b1;
        err_cnt_nx = ((&err_count) || !mismatch)
                   ? err_count : err_count + 1'b1;
    end

    // Fill / search / locked sequencing with registered outputs.
    // Threshold loss takes priority over a window end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FILL;
            locked    <= 1'b0;
            delay_out <= '0;
            bit_count <= '0;
            err_count <= '0;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (valid) begin
            unique case (state)
                FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_last) begin
                        state     <= SEARCH;
                        delay_out <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end
                end
                SEARCH: begin
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_err_nx == '0) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            bit_count <= '0;
                            err_count <= '0;
                        end else begin
                            delay_out <= delay_inc;
                        end
                    end else begin
                        win_cnt <= win_cnt_nx;
                        win_err <= win_err_nx;
                    end
                end
                LOCKED: begin
                    bit_count <= bit_cnt_nx;
                    err_count <= err_cnt_nx;
                    if (thr_hit) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        delay_out <= delay_inc;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end else if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt_nx;
                        win_err <= win_err_nx;
                    end
                end
                default: begin
                    state  <= FILL;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
